commit_dests: RTL and testbench
===============================

// Module: commit_dests
// PURPOSE
//  Write-back end of operand decode: takes the (dest_kind, dest_sel) pairs that operand
//  decode produces, plus the computed result values, and commits them.
//  Owns the 8x32 GPR file (eax..edi) that feeds operand decode.
//  Sequences up to two destinations through one register write port and one memory write port.
// PARAMETERS
//  RESET_ESP   32'h0000_0000  reset value of esp
//  RESET_GPR   32'h0000_0000  reset value of every other GPR
// PORTS
//  clk             in   1   clock
//  rst             in   1   synchronous reset, active-high
//  in_valid        in   1   commit request valid
//  in_ready        out  1   block idle, request accepted when in_valid&in_ready
//  dest0_kind      in   2   one-hot {`OPND_DEST_MEM,`OPND_DEST_REG}; 2'b00 = none
//  dest1_kind      in   2   as dest0_kind
//  dest0_sel       in   32  REG: [2:0] regsel (0=eax..7=edi, [31:3] ignored); MEM: byte address
//  dest1_sel       in   32  as dest0_sel
//  dest0_val       in   32  result for dest0
//  dest1_val       in   32  result for dest1
//  reg_1byte       in   1   8-bit operand size (see CONFIGURATION)
//  prefix_operand_16bit in 1 16-bit operand size (see CONFIGURATION)
//  mem_wr_valid    out  1   memory write request
//  mem_wr_ready    in   1   memory accepts write
//  mem_wr_addr     out  32  write byte address
//  mem_wr_data     out  32  write data
//  mem_wr_bytes    out  4   byte enables
//  commit_done     out  1   one-cycle pulse: both destinations committed
//  commit_err      out  1   sticky: illegal dest_kind 2'b11 seen; cleared only by rst
//  eax,ecx,edx,ebx,esp,ebp,esi,edi  out 32 each  architectural GPRs
// BEHAVIOUR
//  Reset: state IDLE; in_ready=1; mem_wr_valid=0; mem_wr_addr/data=0; mem_wr_bytes=0;
//   commit_done=0; commit_err=0; esp=RESET_ESP; other GPRs=RESET_GPR.
//  FSM states: IDLE -> D0 -> D1 -> IDLE.
//  - IDLE: in_ready=1. On in_valid, latch all dest*/val/size inputs, go to D0. in_ready=0 in all other states.
//  - D0/D1 with kind REG: the GPR is written at the end of that cycle; advance one cycle later.
//  - D0/D1 with kind MEM: mem_wr_valid=1 with addr=sel, data=val.
//     Hold valid and all mem_wr_* fields stable until mem_wr_ready.
//     Advance on the valid&ready cycle. No timeout.
//  - D0/D1 with kind NONE: no write; advance after one cycle.
//  - D0/D1 with kind 2'b11: treated as NONE; set commit_err.
//  - D1 completion cycle: commit_done=1; next state IDLE.
//  Latency: accept at cycle T. With two REG or NONE dests:
//   reg0 visible at T+2, reg1 visible at T+3, commit_done high in T+2, in_ready high in T+3.
//  Both dests REG with the same regsel: the dest1 value wins, since it is written later.
//  GPR outputs are registered; a value written in Dn is visible the cycle after.
//  The latched request is immune to input changes after acceptance.
//  rst mid-operation (including during mem_wr_valid stall): abandon the request.
//   mem_wr_valid drops the next cycle; all reset values apply.
//   No partial write is repeated.
// CONFIGURATION
//  COMMIT_SUBREG_EN defined:
//   - reg_1byte=1, REG kind: sel 0-3 writes bits [7:0] of eax/ecx/edx/ebx (AL,CL,DL,BL);
//     sel 4-7 writes bits [15:8] of eax/ecx/edx/ebx (AH,CH,DH,BH). Other bits are preserved.
//   - reg_1byte=1, MEM kind: mem_wr_bytes=4'b0001.
//   - else prefix_operand_16bit=1, REG kind: write bits [15:0] of the selected reg, preserving [31:16].
//   - else prefix_operand_16bit=1, MEM kind: mem_wr_bytes=4'b0011.
//   - else: full 32-bit write; mem_wr_bytes=4'b1111.
//   - reg_1byte has priority over prefix_operand_16bit.
//  COMMIT_SUBREG_EN undefined: reg_1byte and prefix_operand_16bit are ignored;
//   all writes are 32-bit; mem_wr_bytes=4'b1111.
// TESTING
//  1 rst; dest0=REG sel 1 val 32'hDEAD_BEEF, dest1=NONE
//     -> ecx=DEADBEEF at T+2, commit_done in T+2, other GPRs unchanged.
//  2 dest0=REG sel 3, dest1=REG sel 3, vals 1/2
//     -> ebx=1 at T+2, ebx=2 at T+3.
//  3 dest0=MEM addr 32'h1000 val 5, mem_wr_ready low 4 cycles
//     -> mem_wr_* stable for 5 cycles, then D1; assert rst during a stall -> mem_wr_valid=0 next cycle.
//  4 SUBREG_EN: eax=32'h1122_3344, reg_1byte sel 4 val 32'hAA
//     -> eax=32'h1122_AA44; 16-bit sel 0 val 32'hFFFF_BEEF -> eax=32'h1122_BEEF.
//  5 dest1_kind=2'b11 -> no write; commit_err=1 until rst; commit_done still pulses.
//  6 back-to-back in_valid held high
//     -> accepts only in IDLE; one request per 3 cycles (REG/NONE).

Source files
------------

// File: rtl/commit_dests.sv
// Write-back stage: owns the 8x32 GPR file and commits up to two destinations per request.
// Optional COMMIT_SUBREG_EN enables 8/16-bit register and memory writes.
module commit_dests #(
  parameter logic [31:0] RESET_ESP = 32'h0000_0000,
  parameter logic [31:0] RESET_GPR = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [1:0]  i_dest0_kind,
  input  logic [1:0]  i_dest1_kind,
  input  logic [31:0] i_dest0_sel,
  input  logic [31:0] i_dest1_sel,
  input  logic [31:0] i_dest0_val,
  input  logic [31:0] i_dest1_val,
  input  logic        i_reg_1byte,
  input  logic        i_prefix_operand_16bit,
  output logic        o_mem_wr_valid,
  input  logic        i_mem_wr_ready,
  output logic [31:0] o_mem_wr_addr,
  output logic [31:0] o_mem_wr_data,
  output logic [3:0]  o_mem_wr_bytes,
  output logic        o_commit_done,
  output logic        o_commit_err,
  output logic [31:0] o_eax,
  output logic [31:0] o_ecx,
  output logic [31:0] o_edx,
  output logic [31:0] o_ebx,
  output logic [31:0] o_esp,
  output logic [31:0] o_ebp,
  output logic [31:0] o_esi,
  output logic [31:0] o_edi
);

  localparam logic [1:0] OPND_DEST_REG = 2'b01;
  localparam logic [1:0] OPND_DEST_MEM = 2'b10;
  localparam logic [1:0] OPND_DEST_BAD = 2'b11;

  typedef enum logic [1:0] {StIdle, StD0, StD1} state_e;

  state_e      r_state, w_state_nxt;
  logic [1:0]  r_kind0, r_kind1;
  logic [31:0] r_sel0, r_sel1, r_val0, r_val1;
  logic        r_1byte, r_16bit;
  logic [31:0] r_gpr [8];
  logic        r_err;

  logic [1:0]  w_kind;
  logic [31:0] w_sel, w_val, w_wdata, w_old;
  logic [2:0]  w_widx;
  logic [3:0]  w_bytes;
  logic        w_busy, w_is_d1, w_is_reg, w_is_mem, w_is_bad, w_adv;

  // Current destination slot is chosen by the state.
  always_comb begin
    w_busy   = (r_state != StIdle);
    w_is_d1  = (r_state == StD1);
    w_kind   = w_is_d1 ? r_kind1 : r_kind0;
    w_sel    = w_is_d1 ? r_sel1  : r_sel0;
    w_val    = w_is_d1 ? r_val1  : r_val0;
    w_is_reg = w_busy && (w_kind == OPND_DEST_REG);
    w_is_mem = w_busy && (w_kind == OPND_DEST_MEM);
    w_is_bad = w_busy && (w_kind == OPND_DEST_BAD);
    w_adv    = w_busy && (!w_is_mem || i_mem_wr_ready);
  end

`ifdef COMMIT_SUBREG_EN
  // Byte writes with sel 4-7 target the high byte of eax..ebx (AH..BH).
  always_comb begin
    w_widx = r_1byte ? {1'b0, w_sel[1:0]} : w_sel[2:0];
    w_old  = r_gpr[w_widx];
    if (r_1byte) begin
      w_wdata = w_sel[2] ? {w_old[31:16], w_val[7:0], w_old[7:0]} : {w_old[31:8], w_val[7:0]};
      w_bytes = 4'b0001;
    end else if (r_16bit) begin
      w_wdata = {w_old[31:16], w_val[15:0]};
      w_bytes = 4'b0011;
    end else begin
      w_wdata = w_val;
      w_bytes = 4'b1111;
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{r_1byte, r_16bit};
  always_comb begin
    w_widx  = w_sel[2:0];
    w_old   = r_gpr[w_widx];
    w_wdata = w_val;
    w_bytes = 4'b1111;
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (i_in_valid) w_state_nxt = StD0;
      StD0:    if (w_adv) w_state_nxt = StD1;
      StD1:    if (w_adv) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    o_in_ready     = (r_state == StIdle);
    o_mem_wr_valid = w_is_mem;
    o_mem_wr_addr  = w_is_mem ? w_sel : 32'h0;
    o_mem_wr_data  = w_is_mem ? w_val : 32'h0;
    o_mem_wr_bytes = w_is_mem ? w_bytes : 4'b0000;
    o_commit_done  = w_is_d1 && w_adv;
    o_commit_err   = r_err;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_kind0 <= 2'b00;
      r_kind1 <= 2'b00;
      r_sel0  <= 32'h0;
      r_sel1  <= 32'h0;
      r_val0  <= 32'h0;
      r_val1  <= 32'h0;
      r_1byte <= 1'b0;
      r_16bit <= 1'b0;
    end else if (r_state == StIdle && i_in_valid) begin
      r_kind0 <= i_dest0_kind;
      r_kind1 <= i_dest1_kind;
      r_sel0  <= i_dest0_sel;
      r_sel1  <= i_dest1_sel;
      r_val0  <= i_dest0_val;
      r_val1  <= i_dest1_val;
      r_1byte <= i_reg_1byte;
      r_16bit <= i_prefix_operand_16bit;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 8; i++) r_gpr[i] <= (i == 4) ? RESET_ESP : RESET_GPR;
      r_err <= 1'b0;
    end else begin
      if (w_is_reg) r_gpr[w_widx] <= w_wdata;
      if (w_is_bad) r_err <= 1'b1;
    end
  end

  assign o_eax = r_gpr[0];
  assign o_ecx = r_gpr[1];
  assign o_edx = r_gpr[2];
  assign o_ebx = r_gpr[3];
  assign o_esp = r_gpr[4];
  assign o_ebp = r_gpr[5];
  assign o_esi = r_gpr[6];
  assign o_edi = r_gpr[7];

endmodule

// File: tb/tb_commit_dests.sv
// Directed bench for commit_dests: reset, REG/MEM/NONE sequencing, stalls, reset abort,
// sub-register writes (COMMIT_SUBREG_EN aware), error flag and back-to-back throughput.
module tb_commit_dests;

  localparam logic [31:0] ESP_RST = 32'h0000_8000;
  localparam logic [1:0] KN = 2'b00, KR = 2'b01, KM = 2'b10, KB = 2'b11;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready;
  logic [1:0]  d0_kind, d1_kind;
  logic [31:0] d0_sel, d1_sel, d0_val, d1_val;
  logic        r1b, p16;
  logic        mwv, mwr;
  logic [31:0] mwa, mwd;
  logic [3:0]  mwb;
  logic        done, err;
  logic [31:0] eax, ecx, edx, ebx, esp, ebp, esi, edi;

  int errors = 0;
  int checks = 0;
  int acc_cnt, done_cnt;

  always #5 clk = ~clk;

  commit_dests #(.RESET_ESP(ESP_RST), .RESET_GPR(32'h0)) dut (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_dest0_kind(d0_kind), .i_dest1_kind(d1_kind), .i_dest0_sel(d0_sel), .i_dest1_sel(d1_sel),
    .i_dest0_val(d0_val), .i_dest1_val(d1_val), .i_reg_1byte(r1b),
    .i_prefix_operand_16bit(p16), .o_mem_wr_valid(mwv), .i_mem_wr_ready(mwr),
    .o_mem_wr_addr(mwa), .o_mem_wr_data(mwd), .o_mem_wr_bytes(mwb), .o_commit_done(done),
    .o_commit_err(err), .o_eax(eax), .o_ecx(ecx), .o_edx(edx), .o_ebx(ebx), .o_esp(esp),
    .o_ebp(ebp), .o_esi(esi), .o_edi(edi)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] k0, input logic [31:0] s0, input logic [31:0] v0,
                       input logic [1:0] k1, input logic [31:0] s1, input logic [31:0] v1,
                       input logic b1, input logic h16);
    d0_kind = k0; d0_sel = s0; d0_val = v0;
    d1_kind = k1; d1_sel = s1; d1_val = v1;
    r1b = b1; p16 = h16; in_valid = 1'b1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; mwr = 1'b1;
    d0_kind = KN; d1_kind = KN; d0_sel = '0; d1_sel = '0; d0_val = '0; d1_val = '0;
    r1b = 1'b0; p16 = 1'b0;
    step(); step();
    rst = 1'b0;

    // Reset state
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mwv", 32'(mwv), 32'd0);
    chk("rst_mwa", mwa, 32'h0);
    chk("rst_mwb", 32'(mwb), 32'h0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_eax", eax, 32'h0);
    chk("rst_esp", esp, ESP_RST);
    chk("rst_edi", edi, 32'h0);

    // 1: REG ecx (upper sel bits ignored), dest1 NONE; inputs change after acceptance
    issue(KR, 32'hFFFF_FF01, 32'hDEAD_BEEF, KN, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("t1_accept_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0; d0_sel = 32'h2; d0_val = 32'h1234_5678;
    chk("t1_d0_ready", 32'(in_ready), 32'd0);
    chk("t1_d0_ecx_old", ecx, 32'h0);
    chk("t1_d0_done", 32'(done), 32'd0);
    step();
    chk("t1_ecx", ecx, 32'hDEAD_BEEF);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_edx", edx, 32'h0);
    chk("t1_esp", esp, ESP_RST);
    step();
    chk("t1_idle_ready", 32'(in_ready), 32'd1);
    chk("t1_idle_done", 32'(done), 32'd0);
    chk("t1_edx_immune", edx, 32'h0);

    // 2: both REG ebx, dest1 wins
    issue(KR, 32'h3, 32'h1, KR, 32'h3, 32'h2, 1'b0, 1'b0);
    step(); in_valid = 1'b0;
    step();
    chk("t2_ebx_first", ebx, 32'h1);
    chk("t2_done", 32'(done), 32'd1);
    step();
    chk("t2_ebx_second", ebx, 32'h2);
    chk("t2_ready", 32'(in_ready), 32'd1);

    // 3a: MEM stall for four cycles, then handshake
    mwr = 1'b0;
    issue(KM, 32'h1000, 32'h5, KN, 32'h0, 32'h0, 1'b0, 1'b0);
    step(); in_valid = 1'b0; d0_sel = 32'h9999;
    for (int k = 0; k < 4; k++) begin
      chk("t3_stall_valid", 32'(mwv), 32'd1);
      chk("t3_stall_addr", mwa, 32'h1000);
      chk("t3_stall_data", mwd, 32'h5);
      chk("t3_stall_bytes", 32'(mwb), 32'hF);
      chk("t3_stall_done", 32'(done), 32'd0);
      step();
    end
    mwr = 1'b1;
    chk("t3_hs_valid", 32'(mwv), 32'd1);
    chk("t3_hs_addr", mwa, 32'h1000);
    step();
    chk("t3_d1_valid", 32'(mwv), 32'd0);
    chk("t3_d1_done", 32'(done), 32'd1);
    step();
    chk("t3_idle_ready", 32'(in_ready), 32'd1);

    // 3b: MEM on dest1 with ready high
    issue(KN, 32'h0, 32'h0, KM, 32'h44, 32'h77, 1'b0, 1'b0);
    step(); in_valid = 1'b0;
    chk("t3b_d0_valid", 32'(mwv), 32'd0);
    step();
    chk("t3b_d1_valid", 32'(mwv), 32'd1);
    chk("t3b_d1_addr", mwa, 32'h44);
    chk("t3b_d1_data", mwd, 32'h77);
    chk("t3b_d1_done", 32'(done), 32'd1);
    step();
    chk("t3b_idle_valid", 32'(mwv), 32'd0);

    // 3c: reset during a stall abandons the request
    mwr = 1'b0;
    issue(KM, 32'h2000, 32'h9, KR, 32'h1, 32'h55, 1'b0, 1'b0);
    step(); in_valid = 1'b0;
    chk("t3c_valid", 32'(mwv), 32'd1);
    step();
    rst = 1'b1;
    step();
    chk("t3c_rst_valid", 32'(mwv), 32'd0);
    chk("t3c_rst_addr", mwa, 32'h0);
    chk("t3c_rst_ready", 32'(in_ready), 32'd1);
    chk("t3c_rst_ebx", ebx, 32'h0);
    chk("t3c_rst_ecx", ecx, 32'h0);
    rst = 1'b0; mwr = 1'b1;
    step();
    chk("t3c_after_valid", 32'(mwv), 32'd0);
    chk("t3c_after_ecx", ecx, 32'h0);

    // 4: sub-register writes
    issue(KR, 32'h0, 32'h1122_3344, KN, 32'h0, 32'h0, 1'b0, 1'b0);
    step(); in_valid = 1'b0; step(); step();
    chk("t4_eax_full", eax, 32'h1122_3344);
    issue(KR, 32'h4, 32'h0000_00AA, KN, 32'h0, 32'h0, 1'b1, 1'b1);
    step(); in_valid = 1'b0; step(); step();
`ifdef COMMIT_SUBREG_EN
    chk("t4_ah", eax, 32'h1122_AA44);
    chk("t4_ah_esp", esp, ESP_RST);
`else
    chk("t4_b_eax", eax, 32'h1122_3344);
    chk("t4_b_esp", esp, 32'h0000_00AA);
`endif
    issue(KR, 32'h0, 32'hFFFF_BEEF, KN, 32'h0, 32'h0, 1'b0, 1'b1);
    step(); in_valid = 1'b0; step(); step();
`ifdef COMMIT_SUBREG_EN
    chk("t4_ax", eax, 32'h1122_BEEF);
`else
    chk("t4_w_eax", eax, 32'hFFFF_BEEF);
`endif
    issue(KM, 32'h300, 32'hAB, KM, 32'h304, 32'hCD, 1'b1, 1'b0);
    step(); in_valid = 1'b0;
`ifdef COMMIT_SUBREG_EN
    chk("t4_mem_b", 32'(mwb), 32'h1);
`else
    chk("t4_mem_b", 32'(mwb), 32'hF);
`endif
    step();
    chk("t4_mem_d1_addr", mwa, 32'h304);
    step();

    // 5: illegal kind on dest1
    issue(KR, 32'h2, 32'h55, KB, 32'h2, 32'h66, 1'b0, 1'b0);
    step(); in_valid = 1'b0;
    chk("t5_err_d0", 32'(err), 32'd0);
    step();
    chk("t5_edx", edx, 32'h55);
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_mwv", 32'(mwv), 32'd0);
    step();
    chk("t5_err_set", 32'(err), 32'd1);
    chk("t5_edx_kept", edx, 32'h55);
    issue(KN, 32'h0, 32'h0, KN, 32'h0, 32'h0, 1'b0, 1'b0);
    step(); in_valid = 1'b0; step(); step();
    chk("t5_err_sticky", 32'(err), 32'd1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("t5_err_clr", 32'(err), 32'd0);

    // 6: in_valid held high, one accept per three cycles
    acc_cnt = 0; done_cnt = 0;
    issue(KR, 32'h6, 32'h600, KN, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      chk("t6_ready_pattern", 32'(in_ready), (i % 3 == 0) ? 32'd1 : 32'd0);
      if (in_ready) acc_cnt++;
      if (done) done_cnt++;
      step();
    end
    in_valid = 1'b0;
    chk("t6_accepts", 32'(acc_cnt), 32'd3);
    chk("t6_dones", 32'(done_cnt), 32'd3);
    chk("t6_esi", esi, 32'h600);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
